// File: rtl/alu_cmd_pkg.sv
// Shared state type, framing nibbles and error codes for the ALU command sequencer.
package alu_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RX_A,
        RX_B,
        ISSUE,
        WAIT_RES,
        TX
    } state_t;

    localparam logic [3:0] SYNC_NIBBLE = 4'hA;
    localparam logic [3:0] RESP_NIBBLE = 4'h5;
    localparam logic [7:0] ERR_BAD_OP  = 8'hEE;
    localparam logic [7:0] ERR_RX      = 8'hEF;
    localparam logic [7:0] ERR_TIMEOUT = 8'hED;

    function automatic logic opcode_ok(input logic [7:0] b, input int num_ops);
        return (b[7:4] == SYNC_NIBBLE) && (int'(b[3:0]) < num_ops);
    endfunction

endpackage

// File: rtl/alu_cmd_tx_ser.sv
// Byte serializer: loads a little-endian byte vector plus length, then drives an AXI-stream master.
module alu_cmd_tx_ser
    #(
        parameter int DATA_WIDTH = 8,
        parameter int MAX_BYTES  = 5,
        parameter int LW         = $clog2(MAX_BYTES + 1)
    )
    (
        input  logic                          clk,
        input  logic                          rst,
        input  logic                          load,
        input  logic [LW-1:0]                 load_len,
        input  logic [MAX_BYTES*DATA_WIDTH-1:0] load_bytes,
        output logic [DATA_WIDTH-1:0]         m_axis_tdata,
        output logic                          m_axis_tvalid,
        input  logic                          m_axis_tready,
        output logic                          done
    );

    logic [MAX_BYTES*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [LW-1:0]                   rem_q, rem_d;

    always_comb begin
        buf_d = buf_q;
        rem_d = rem_q;
        done  = 1'b0;
        if (load) begin
            buf_d = load_bytes;
            rem_d = load_len;
        end else if ((rem_q != '0) && m_axis_tready) begin
            buf_d = buf_q >> DATA_WIDTH;
            rem_d = rem_q - 1'b1;
            done  = (rem_q == LW'(1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q <= '0;
            rem_q <= '0;
        end else begin
            buf_q <= buf_d;
            rem_q <= rem_d;
        end
    end

    assign m_axis_tdata  = buf_q[DATA_WIDTH-1:0];
    assign m_axis_tvalid = (rem_q != '0);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// Command sequencer uart_rx -> ALU -> uart_tx with single-byte error replies.
// Optional inter-byte timeout in the operand states is enabled by defining ALU_CMD_TIMEOUT_EN.
//   state    | meaning
//   IDLE     | waiting for an opcode byte
//   RX_A     | collecting operand A bytes, LSB first
//   RX_B     | collecting operand B bytes, LSB first
//   ISSUE    | alu_req_valid held until accepted
//   WAIT_RES | waiting for the ALU result pulse
//   TX       | serializer draining the response or error code
module alu_cmd_ctrl
    import alu_cmd_pkg::*;
    #(
        parameter int DATA_WIDTH     = 8,
        parameter int OPERAND_BYTES  = 4,
        parameter int NUM_OPS        = 8,
        parameter int TIMEOUT_CYCLES = 1000000
    )
    (
        input  logic                               clk,
        input  logic                               rst,
        input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
        input  logic                               s_axis_tvalid,
        output logic                               s_axis_tready,
        input  logic                               rx_frame_error,
        input  logic                               rx_overrun_error,
        output logic [3:0]                         alu_op,
        output logic [OPERAND_BYTES*DATA_WIDTH-1:0] alu_a,
        output logic [OPERAND_BYTES*DATA_WIDTH-1:0] alu_b,
        output logic                               alu_req_valid,
        input  logic                               alu_req_ready,
        input  logic                               alu_res_valid,
        input  logic [OPERAND_BYTES*DATA_WIDTH-1:0] alu_res_data,
        output logic [DATA_WIDTH-1:0]              m_axis_tdata,
        output logic                               m_axis_tvalid,
        input  logic                               m_axis_tready,
        output logic                               busy,
        output logic                               cmd_error
    );

    localparam int W  = OPERAND_BYTES * DATA_WIDTH;
    localparam int NB = OPERAND_BYTES + 1;
    localparam int VW = NB * DATA_WIDTH;
    localparam int LW = $clog2(NB + 1);
    localparam int CW = $clog2(OPERAND_BYTES + 1);

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d;
    logic            req_q, req_d, err_q, err_d, busy_q, busy_d, tready_q, tready_d;
    logic            acc, rx_err, tmo_hit, tx_done, ld;
    logic [LW-1:0]   ld_len;
    logic [VW-1:0]   ld_bytes;

    assign acc    = s_axis_tvalid & tready_q;
    assign rx_err = rx_frame_error | rx_overrun_error;

`ifdef ALU_CMD_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmr_q, tmr_d;

    // Down-counter reloads on every accepted byte and outside the operand states.
    always_comb begin
        tmr_d = TW'(TIMEOUT_CYCLES - 1);
        if (((state_q == RX_A) || (state_q == RX_B)) && !acc && (tmr_q != '0))
            tmr_d = tmr_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tmr_q <= TW'(TIMEOUT_CYCLES - 1);
        else      tmr_q <= tmr_d;
    end

    assign tmo_hit = (tmr_q == '0);
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        req_d    = req_q;
        err_d    = 1'b0;
        ld       = 1'b0;
        ld_len   = '0;
        ld_bytes = '0;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (opcode_ok(s_axis_tdata[7:0], NUM_OPS)) begin
                        op_d    = s_axis_tdata[3:0];
                        cnt_d   = '0;
                        state_d = RX_A;
                    end else begin
                        err_d    = 1'b1;
                        ld       = 1'b1;
                        ld_len   = LW'(1);
                        ld_bytes = VW'(ERR_BAD_OP);
                        state_d  = TX;
                    end
                end
            end
            RX_A, RX_B: begin
                // A line error discards any byte accepted alongside it, including the last one.
                if (rx_err) begin
                    err_d    = 1'b1;
                    ld       = 1'b1;
                    ld_len   = LW'(1);
                    ld_bytes = VW'(ERR_RX);
                    state_d  = TX;
                end else if (acc) begin
                    if (state_q == RX_A) a_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
                    else                 b_d[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
                    if (cnt_q == CW'(OPERAND_BYTES - 1)) begin
                        cnt_d = '0;
                        if (state_q == RX_A) begin
                            state_d = RX_B;
                        end else begin
                            state_d = ISSUE;
                            req_d   = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (tmo_hit) begin
                    err_d    = 1'b1;
                    ld       = 1'b1;
                    ld_len   = LW'(1);
                    ld_bytes = VW'(ERR_TIMEOUT);
                    state_d  = TX;
                end
            end
            ISSUE: begin
                if (alu_req_ready) begin
                    req_d   = 1'b0;
                    state_d = WAIT_RES;
                end
            end
            WAIT_RES: begin
                if (alu_res_valid) begin
                    ld       = 1'b1;
                    ld_len   = LW'(NB);
                    ld_bytes = {alu_res_data, DATA_WIDTH'({RESP_NIBBLE, op_q})};
                    state_d  = TX;
                end
            end
            TX: begin
                if (tx_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d != IDLE);
        tready_d = (state_d == IDLE) || (state_d == RX_A) || (state_d == RX_B);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            req_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            tready_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            req_q    <= req_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            tready_q <= tready_d;
        end
    end

    alu_cmd_tx_ser #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BYTES  (NB),
        .LW         (LW)
    ) u_tx_ser (
        .clk           (clk),
        .rst           (rst),
        .load          (ld),
        .load_len      (ld_len),
        .load_bytes    (ld_bytes),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .done          (tx_done)
    );

    assign s_axis_tready = tready_q;
    assign alu_op        = op_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;
    assign alu_req_valid = req_q;
    assign busy          = busy_q;
    assign cmd_error     = err_q;

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Self-checking bench for alu_cmd_ctrl; expected replies come from the framing rules, not the RTL.
module tb_alu_cmd_ctrl;
    localparam int OB   = 4;
    localparam int W    = OB * 8;
    localparam int NOPS = 8;
    localparam int TMO  = 50;
    localparam int RW   = 8 * (OB + 1);

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   s_axis_tdata;
    logic         s_axis_tvalid, s_axis_tready, rx_frame_error, rx_overrun_error;
    logic [3:0]   alu_op;
    logic [W-1:0] alu_a, alu_b, alu_res_data;
    logic         alu_req_valid, alu_req_ready, alu_res_valid;
    logic [7:0]   m_axis_tdata;
    logic         m_axis_tvalid, m_axis_tready, busy, cmd_error;

    int tests_run = 0, tests_failed = 0;
    int err_pulses = 0, req_hs = 0;

    logic [7:0]   got_q[$];
    logic [3:0]   obs_op;
    logic [W-1:0] obs_a, obs_b;
    bit           obs_ok, obs_req_stable, obs_tx_stable;

    alu_cmd_ctrl #(
        .DATA_WIDTH(8), .OPERAND_BYTES(OB), .NUM_OPS(NOPS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .rx_frame_error(rx_frame_error), .rx_overrun_error(rx_overrun_error),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
        .alu_res_valid(alu_res_valid), .alu_res_data(alu_res_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .busy(busy), .cmd_error(cmd_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cmd_error) err_pulses <= err_pulses + 1;
        if (alu_req_valid && alu_req_ready) req_hs <= req_hs + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    function automatic logic [RW-1:0] got_vec();
        logic [RW-1:0] v = '0;
        foreach (got_q[i]) if (i < OB + 1) v[8*i +: 8] = got_q[i];
        return v;
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic ferr, input logic oerr, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (s_axis_tready) begin ok = 1'b1; break; end
        end
        if (!ok) return;
        s_axis_tvalid = 1'b1; s_axis_tdata = b; rx_frame_error = ferr; rx_overrun_error = oerr;
        @(negedge clk);
        s_axis_tvalid = 1'b0; rx_frame_error = 1'b0; rx_overrun_error = 1'b0;
    endtask

    task automatic alu_serve(input int stall, input logic [W-1:0] res, output bit ok);
        ok = 1'b0; obs_req_stable = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (alu_req_valid) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        if (!ok) return;
        obs_op = alu_op; obs_a = alu_a; obs_b = alu_b;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            if (!alu_req_valid || alu_op !== obs_op || alu_a !== obs_a || alu_b !== obs_b)
                obs_req_stable = 1'b0;
        end
        alu_req_ready = 1'b1;
        @(negedge clk);
        alu_req_ready = 1'b0;
        if (alu_req_valid) obs_req_stable = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
        alu_res_valid = 1'b1; alu_res_data = res;
        @(negedge clk);
        alu_res_valid = 1'b0; alu_res_data = '0;
    endtask

    // mode 0: always ready, 1: toggling, 2: random
    task automatic collect(input int n, input int mode, output bit ok);
        bit vp = 1'b0, rp = 1'b0;
        logic [7:0] dp = '0;
        got_q = {}; obs_tx_stable = 1'b1; ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (vp && rp) got_q.push_back(dp);
            else if (vp && (!m_axis_tvalid || m_axis_tdata !== dp)) obs_tx_stable = 1'b0;
            if (got_q.size() == n) begin ok = 1'b1; break; end
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (i % 2 == 0);
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            vp = m_axis_tvalid; dp = m_axis_tdata; rp = m_axis_tready;
        end
        m_axis_tready = 1'b0;
    endtask

    task automatic do_cmd(input logic [7:0] opb, input logic [W-1:0] a, input logic [W-1:0] b,
                          input int stall, input logic [W-1:0] res, input int mode);
        bit ok;
        obs_ok = 1'b1;
        send_byte(opb, 1'b0, 1'b0, ok); obs_ok &= ok;
        for (int k = 0; k < OB; k++) begin send_byte(a[8*k +: 8], 1'b0, 1'b0, ok); obs_ok &= ok; end
        for (int k = 0; k < OB; k++) begin send_byte(b[8*k +: 8], 1'b0, 1'b0, ok); obs_ok &= ok; end
        alu_serve(stall, res, ok); obs_ok &= ok;
        collect(OB + 1, mode, ok); obs_ok &= ok;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        tests_run++;
        if ({s_axis_tready, busy, m_axis_tvalid, alu_req_valid, cmd_error} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: got %b expected 00000", {s_axis_tready, busy, m_axis_tvalid, alu_req_valid, cmd_error});
        end
        tests_run++;
        if (alu_op !== 4'h0 || alu_a !== '0 || alu_b !== '0 || m_axis_tdata !== 8'h0) begin
            tests_failed++;
            $display("FAIL reset_data: got op=%h a=%h b=%h tdata=%h expected all zero", alu_op, alu_a, alu_b, m_axis_tdata);
        end
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if (s_axis_tready !== 1'b1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: got tready=%b busy=%b expected tready=1 busy=0", s_axis_tready, busy);
        end
    endtask

    task automatic test_basic();
        int e0 = err_pulses, h0 = req_hs;
        do_cmd(8'hA0, 32'd1, 32'd2, 0, 32'd3, 0);
        tests_run++;
        if (!obs_ok || obs_op !== 4'h0 || obs_a !== 32'd1 || obs_b !== 32'd2) begin
            tests_failed++;
            $display("FAIL basic_req: got ok=%b op=%h a=%h b=%h expected op=0 a=1 b=2", obs_ok, obs_op, obs_a, obs_b);
        end
        tests_run++;
        if (got_q.size() != OB + 1 || got_vec() !== 40'h00_0000_0350) begin
            tests_failed++;
            $display("FAIL basic_resp: got %0d bytes %h expected 5 bytes 0000000350", got_q.size(), got_vec());
        end
        tests_run++;
        if (req_hs - h0 != 1 || err_pulses != e0 || busy !== 1'b0 || m_axis_tvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL basic_side: got hs=%0d err=%0d busy=%b tvalid=%b expected 1 0 0 0", req_hs - h0, err_pulses - e0, busy, m_axis_tvalid);
        end
    endtask

    task automatic test_bad_op();
        logic [7:0] bytes_in[2] = '{8'h3F, 8'h17};
        bit ok;
        foreach (bytes_in[i]) begin
            int e0 = err_pulses;
            send_byte(bytes_in[i], 1'b0, 1'b0, ok);
            collect(1, 0, ok);
            tests_run++;
            if (!ok || got_q[0] !== 8'hEE || err_pulses - e0 != 1 || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL bad_op_%h: got ok=%b byte=%h err=%0d busy=%b expected EE 1 0", bytes_in[i], ok, ok ? got_q[0] : 8'hxx, err_pulses - e0, busy);
            end
        end
        // A stray result pulse while idle must not produce output.
        @(negedge clk); alu_res_valid = 1'b1; alu_res_data = 32'hDEAD_BEEF;
        @(negedge clk); alu_res_valid = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL stray_result: got tvalid=%b busy=%b expected 0 0", m_axis_tvalid, busy);
        end
    endtask

    task automatic test_rx_error();
        bit ok;
        int e0 = err_pulses;
        send_byte(8'hA1, 1'b0, 1'b0, ok);
        send_byte(8'h11, 1'b0, 1'b0, ok);
        send_byte(8'h22, 1'b0, 1'b0, ok);
        @(negedge clk); rx_frame_error = 1'b1;
        @(negedge clk); rx_frame_error = 1'b0;
        collect(1, 0, ok);
        tests_run++;
        if (!ok || got_q[0] !== 8'hEF || err_pulses - e0 != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_frame_err: got ok=%b err=%0d busy=%b expected EF 1 0", ok, err_pulses - e0, busy);
        end
        // Overrun on the very last B byte wins over the command completing.
        e0 = err_pulses;
        send_byte(8'hA4, 1'b0, 1'b0, ok);
        for (int k = 0; k < 2 * OB - 1; k++) send_byte(8'(k), 1'b0, 1'b0, ok);
        send_byte(8'h77, 1'b0, 1'b1, ok);
        collect(1, 0, ok);
        tests_run++;
        if (!ok || got_q[0] !== 8'hEF || err_pulses - e0 != 1 || alu_req_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL rx_err_last_byte: got ok=%b err=%0d req=%b expected EF 1 0", ok, err_pulses - e0, alu_req_valid);
        end
        do_cmd(8'hA5, 32'h0102_0304, 32'hA0B0_C0D0, 1, 32'h1234_5678, 0);
        tests_run++;
        if (!obs_ok || obs_op !== 4'h5 || obs_a !== 32'h0102_0304 || obs_b !== 32'hA0B0_C0D0 ||
            got_vec() !== {32'h1234_5678, 8'h55}) begin
            tests_failed++;
            $display("FAIL rx_err_recover: got op=%h a=%h b=%h resp=%h expected 5 01020304 a0b0c0d0 %h", obs_op, obs_a, obs_b, got_vec(), {32'h1234_5678, 8'h55});
        end
    endtask

    task automatic test_back_to_back();
        do_cmd(8'hA7, 32'hFFFF_FFFF, 32'h8000_0001, 5, 32'hCAFE_F00D, 1);
        tests_run++;
        if (!obs_ok || !obs_req_stable || obs_op !== 4'h7 || obs_a !== 32'hFFFF_FFFF || obs_b !== 32'h8000_0001) begin
            tests_failed++;
            $display("FAIL stall_req: got ok=%b stable=%b op=%h a=%h b=%h expected stable op=7", obs_ok, obs_req_stable, obs_op, obs_a, obs_b);
        end
        tests_run++;
        if (!obs_tx_stable || got_q.size() != OB + 1 || got_vec() !== {32'hCAFE_F00D, 8'h57}) begin
            tests_failed++;
            $display("FAIL toggle_tx: got stable=%b n=%0d resp=%h expected %h", obs_tx_stable, got_q.size(), got_vec(), {32'hCAFE_F00D, 8'h57});
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 30; it++) begin
            int kind = $urandom_range(0, 9);
            int e0 = err_pulses, h0 = req_hs;
            logic [RW-1:0] exp_v;
            int exp_n, exp_err, exp_hs;
            if (kind < 6) begin
                logic [3:0] op = 4'($urandom_range(0, NOPS - 1));
                logic [W-1:0] a = $urandom, b = $urandom, r = $urandom;
                do_cmd({4'hA, op}, a, b, $urandom_range(0, 4), r, 2);
                ok = obs_ok && obs_req_stable && obs_op === op && obs_a === a && obs_b === b;
                exp_v = {r, 4'h5, op}; exp_n = OB + 1; exp_err = 0; exp_hs = 1;
            end else if (kind < 8) begin
                logic [7:0] bb;
                do bb = 8'($urandom); while (bb[7:4] == 4'hA && bb[3:0] < NOPS);
                send_byte(bb, 1'b0, 1'b0, ok);
                collect(1, 2, ok);
                exp_v = RW'(8'hEE); exp_n = 1; exp_err = 1; exp_hs = 0;
            end else begin
                int k = $urandom_range(0, 2 * OB - 1);
                bit f = 1'($urandom_range(0, 1));
                send_byte(8'hA3, 1'b0, 1'b0, ok);
                for (int j = 0; j < k; j++) send_byte(8'($urandom), 1'b0, 1'b0, ok);
                send_byte(8'($urandom), f, !f, ok);
                collect(1, 2, ok);
                exp_v = RW'(8'hEF); exp_n = 1; exp_err = 1; exp_hs = 0;
            end
            tests_run++;
            if (!ok || !obs_tx_stable || got_q.size() != exp_n || got_vec() !== exp_v ||
                err_pulses - e0 != exp_err || req_hs - h0 != exp_hs || busy !== 1'b0) begin
                tests_failed++;
                $display("FAIL random_%0d kind=%0d: got ok=%b n=%0d resp=%h err=%0d hs=%0d busy=%b expected n=%0d resp=%h err=%0d hs=%0d busy=0",
                         it, kind, ok, got_q.size(), got_vec(), err_pulses - e0, req_hs - h0, busy, exp_n, exp_v, exp_err, exp_hs);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        send_byte(8'hA3, 1'b0, 1'b0, ok);
        for (int k = 0; k < OB + 2; k++) send_byte(8'h40 + 8'(k), 1'b0, 1'b0, ok);
        #2 rst = 1'b0;
        #1;
        tests_run++;
        if ({s_axis_tready, busy, alu_req_valid, m_axis_tvalid, cmd_error} !== 5'b0 || alu_a !== '0 || alu_op !== 4'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: got ctrl=%b a=%h op=%h expected all zero", {s_axis_tready, busy, alu_req_valid, m_axis_tvalid, cmd_error}, alu_a, alu_op);
        end
        @(negedge clk); rst = 1'b1;
        do_cmd(8'hA6, 32'h0000_00AA, 32'h0000_0055, 0, 32'h0000_00FF, 0);
        tests_run++;
        if (!obs_ok || obs_op !== 4'h6 || obs_a !== 32'hAA || obs_b !== 32'h55 || got_vec() !== {32'hFF, 8'h56}) begin
            tests_failed++;
            $display("FAIL reset_mid_next: got op=%h a=%h b=%h resp=%h expected 6 aa 55 %h", obs_op, obs_a, obs_b, got_vec(), {32'hFF, 8'h56});
        end
    endtask

    task automatic test_timeout();
        bit ok, seen = 1'b0;
        int n = 0, e0 = err_pulses;
        send_byte(8'hA2, 1'b0, 1'b0, ok);
`ifdef ALU_CMD_TIMEOUT_EN
        for (int i = 1; i <= TMO + 20; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) begin n = i; seen = 1'b1; break; end
        end
        tests_run++;
        if (!seen || n != TMO) begin
            tests_failed++;
            $display("FAIL timeout_latency: got seen=%b cycles=%0d expected %0d", seen, n, TMO);
        end
        collect(1, 0, ok);
        tests_run++;
        if (!ok || got_q[0] !== 8'hED || err_pulses - e0 != 1 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL timeout_code: got ok=%b err=%0d busy=%b expected ED 1 0", ok, err_pulses - e0, busy);
        end
`else
        for (int i = 0; i < TMO + 50; i++) begin
            @(negedge clk);
            if (m_axis_tvalid) begin seen = 1'b1; n = i; end
        end
        tests_run++;
        if (seen || busy !== 1'b1 || err_pulses != e0) begin
            tests_failed++;
            $display("FAIL no_timeout: got seen=%b at %0d busy=%b err=%0d expected no output, busy=1, err=0", seen, n, busy, err_pulses - e0);
        end
        rst = 1'b0;
        @(negedge clk); rst = 1'b1;
`endif
    endtask

    initial begin
        s_axis_tdata = '0; s_axis_tvalid = 1'b0; rx_frame_error = 1'b0; rx_overrun_error = 1'b0;
        alu_req_ready = 1'b0; alu_res_valid = 1'b0; alu_res_data = '0; m_axis_tready = 1'b0;
        test_reset();
        test_basic();
        test_bad_op();
        test_rx_error();
        test_back_to_back();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_cmd_ctrl.md
Name: alu_cmd_ctrl

Overview:
Command sequencer between uart_rx (AXI-stream bytes in), the ALU (request/result handshake) and uart_tx (AXI-stream bytes out). Receives a framed command (opcode byte, operand A, operand B, each operand little-endian), issues one ALU operation, then serializes a header byte and the result back out. Malformed, corrupted or stalled commands produce single-byte error codes, and the parser then resynchronizes.

Parameters:
DATA_WIDTH, 8, UART byte width on both AXI-stream sides
OPERAND_BYTES, 4, bytes per operand/result; W = OPERAND_BYTES*DATA_WIDTH
NUM_OPS, 8, valid opcodes are 0..NUM_OPS-1 (max 16)
TIMEOUT_CYCLES, 1000000, inter-byte timeout in clk cycles (used only with ALU_CMD_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
s_axis_tdata  in  DATA_WIDTH  byte from uart_rx
s_axis_tvalid  in  1  byte valid
s_axis_tready  out  1  byte accept
rx_frame_error  in  1  uart_rx frame_error
rx_overrun_error  in  1  uart_rx overrun_error
alu_op  out  4  opcode to ALU
alu_a  out  W  operand A
alu_b  out  W  operand B
alu_req_valid  out  1  ALU request valid
alu_req_ready  in  1  ALU request accept
alu_res_valid  in  1  ALU result valid (single-cycle pulse)
alu_res_data  in  W  ALU result
m_axis_tdata  out  DATA_WIDTH  byte to uart_tx
m_axis_tvalid  out  1  byte valid
m_axis_tready  in  1  uart_tx accept
busy  out  1  high in any state other than IDLE
cmd_error  out  1  one-cycle pulse when an error code is queued

Behaviour:
- Reset (rst low, asynchronous): state IDLE. All outputs are 0, except s_axis_tready, which is 1 once rst is released.
- States: IDLE, RX_A, RX_B, ISSUE, WAIT_RES, TX, with byte counter cnt.
- s_axis_tready = 1 only in IDLE/RX_A/RX_B. Elsewhere, input is back-pressured; uart_rx overrun reporting covers any lost bytes.
- IDLE: on an accepted byte b, validate:
  - b[7:4] == 4'hA and b[3:0] < NUM_OPS: latch alu_op = b[3:0], cnt = 0, go to RX_A.
  - Otherwise: queue error 0xEE, pulse cmd_error, go to TX (1 byte).
- RX_A/RX_B: byte k (k = cnt) is written to operand bits [8k+7:8k]. After the OPERAND_BYTES-th byte, advance (RX_A->RX_B, cnt = 0; RX_B->ISSUE).
- rx_frame_error or rx_overrun_error high in RX_A/RX_B: abort the command, queue 0xEF, pulse cmd_error, go to TX. The byte accepted in the same cycle is discarded. These flags are ignored in other states.
- ISSUE: alu_req_valid = 1 the cycle after the last B byte is accepted. alu_op/alu_a/alu_b stay stable until alu_req_valid & alu_req_ready; then go to WAIT_RES.
- WAIT_RES: on alu_res_valid, latch the result and go to TX with 1+OPERAND_BYTES bytes: header {4'h5, alu_op}, then result bytes LSB first. A result pulse in any other state is ignored.
- TX: m_axis_tvalid is held with tdata stable until m_axis_tready. The next byte is presented the cycle after the handshake. After the last byte, go to IDLE.
- Simultaneous error flag and last operand byte: the error wins.
- There is no mid-command resync on stray 0xA_ bytes; operand bytes are accepted as raw data.

Optional Feature:
Macro ALU_CMD_TIMEOUT_EN.
- Defined: a counter runs in RX_A/RX_B, cleared on each accepted byte. When it reaches TIMEOUT_CYCLES-1: queue 0xED, pulse cmd_error, go to TX.
- Undefined: no counter; RX states wait indefinitely.

Decomposition:
- Package alu_cmd_pkg: state_t enum; localparams SYNC_NIBBLE = 4'hA, RESP_NIBBLE = 4'h5, ERR_BAD_OP = 8'hEE, ERR_RX = 8'hEF, ERR_TIMEOUT = 8'hED.
- Sub-module alu_cmd_tx_ser: loads a byte vector and length, then drives m_axis until done.

Test Plan:
- Stimulus: bytes A0, 01 00 00 00, 02 00 00 00; ALU model returns 3.
  Response: alu_op=0, alu_a=1, alu_b=2, one request handshake; output 50 03 00 00 00.
- Stimulus: byte 3F, then byte 17.
  Response: output EE, cmd_error pulse once. Byte 17 also yields EE. busy returns low after each.
- Stimulus: A1, 2 bytes of A, rx_frame_error pulse.
  Response: output EF, state IDLE. Then a fresh full command completes normally.
- Stimulus: alu_req_ready low for 5 cycles; m_axis_tready toggling 1/0 during the response.
  Response: request and tdata stay stable, no dropped or duplicated bytes.
- Stimulus: rst low mid-RX_B.
  Response: outputs 0 immediately; the next command is parsed from the opcode.
- Stimulus: with ALU_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=50, send A2 and stop.
  Response: ED output 50 cycles after the last byte. Without the macro, no output.
